// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side controller: default widths,
// FIFO geometry, FSM state encoding and the read-credit helper.
package fifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 4;
  localparam int BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    ERR   = 2'b11
  } state_t;

  // A new read may be issued only if every word already committed
  // (buffered plus in flight, minus the one leaving this cycle) still
  // leaves room in the 2-entry output buffer.
  function automatic logic slot_free(input logic [1:0] occ,
                                     input logic       infl,
                                     input logic       pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    return committed < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Two-entry ordered output buffer. slot0 always holds the oldest word and
// drives dout; a push and a pop in the same cycle leave occ unchanged.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && (occ != 2'd0);
  assign push_ok = push && ((occ != 2'(BUF_DEPTH)) || pop_ok);
  assign dout    = slot0;

  // Shift/fill the two slots so the oldest word always sits in slot0.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      occ   <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (occ == 2'd0) slot0 <= din;
          else             slot1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: pulls words from a FIFO with a one-cycle response
// latency into a 2-entry buffer and presents them on a valid/ready port.
// Failed reads (no rd_ack in a response cycle) are counted, saturating.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty,
  input  logic [CNT_W-1:0]  data_count,
  output logic              rd_en,
  input  logic              rd_ack,
  input  logic              rd_err,
  input  logic [DATA_W-1:0] dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ERR_W-1:0]  err_cnt
);

  state_t     state;
  state_t     state_next;
  logic [1:0] occ;
  logic [1:0] occ_next;
  logic       infl;
  logic       pop;
  logic       push;
  logic       failed;
  logic       unused_status;

  // Occupancy is informational only, and a failed read is recognised by the
  // absence of rd_ack, so rd_err carries no extra information here.
  assign unused_status = ^{data_count, rd_err} ^ (data_count > CNT_W'(FIFO_DEPTH));

  assign m_valid  = (occ != 2'd0);
  assign pop      = m_valid && m_ready;
  assign push     = infl && rd_ack;
  assign failed   = infl && !rd_ack;
  assign occ_next = 2'(occ + {1'b0, push} - {1'b0, pop});
  assign rd_en    = !reset && !empty && (state != ERR) && slot_free(occ, infl, pop);

  fifo_rd_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (dout),
    .dout (m_data),
    .occ  (occ)
  );

  // State, in-flight flag and saturating error counter; reset drops any
  // response still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      infl    <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_next;
      infl  <= rd_en;
      if (failed && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  // Next-state logic; ERR decides between IDLE and FETCH on the occupancy
  // left after its own cycle, since a late response may still land in ERR.
  always_comb begin
    state_next = state;
    if (failed) begin
      state_next = ERR;
    end else begin
      case (state)
        IDLE:  if (rd_en) state_next = FETCH;
        FETCH: begin
          if (occ_next == 2'(BUF_DEPTH))          state_next = HOLD;
          else if ((occ_next == 2'd0) && !rd_en)  state_next = IDLE;
        end
        HOLD:  if (pop) state_next = FETCH;
        ERR:   state_next = (occ_next == 2'd0) ? IDLE : FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a queue-based FIFO model answers reads one cycle
// later, every word handed out is pushed to a scoreboard, and a monitor pops
// and compares whenever the downstream port transfers a word.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int DATA_W = 32;
  localparam int ERR_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              empty = 1'b1;
  logic [CNT_W-1:0]  data_count = '0;
  logic              rd_en;
  logic              rd_ack = 1'b0;
  logic              rd_err = 1'b0;
  logic [DATA_W-1:0] dout = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [ERR_W-1:0]  err_cnt;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] sb[$];
  int force_err = 0;
  int fails = 0;
  int delivered = 0;
  bit spurious = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .empty(empty), .data_count(data_count),
    .rd_en(rd_en), .rd_ack(rd_ack), .rd_err(rd_err), .dout(dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_cnt(err_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void updateFlags();
    empty      = (fifo_q.size() == 0);
    data_count = CNT_W'(fifo_q.size());
  endfunction

  function automatic int expErr();
    return (fails > 3) ? 3 : fails;
  endfunction

  task automatic applyStimulus(input int n, input logic [DATA_W-1:0] first,
                               input logic [DATA_W-1:0] step);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + DATA_W'(i) * step);
    updateFlags();
  endtask

  task automatic assertReset();
    @(posedge clk); #2;
    reset = 1'b1;
    m_ready = 1'b0;
    fifo_q.delete();
    sb.delete();
    fails = 0;
    force_err = 0;
    spurious = 1'b0;
    updateFlags();
    @(posedge clk);
  endtask

  task automatic releaseReset();
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && sb.size() == 0 && !m_valid && !rd_en && !rd_ack) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_in_time", done, 1);
  endtask

  // FIFO model: sample the request just before the edge, answer just after.
  initial begin
    bit req;
    forever begin
      @(negedge clk); #4;
      req = rd_en;
      @(posedge clk); #1;
      rd_ack = 1'b0;
      rd_err = 1'b0;
      if (spurious) begin
        rd_ack   = 1'b1;
        dout     = 32'hDEAD_BEEF;
        spurious = 1'b0;
      end else if (req) begin
        if (force_err > 0) begin
          rd_err = 1'b1;
          force_err--;
          fails++;
        end else if (fifo_q.size() > 0) begin
          dout   = fifo_q.pop_front();
          rd_ack = 1'b1;
          sb.push_back(dout);
        end else begin
          rd_err = 1'b1;
          fails++;
        end
      end
      updateFlags();
    end
  end

  // Monitor: order, hold-under-backpressure and no reads while in ERR.
  initial begin
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] exp_word;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", m_valid, 1);
          checkOutput("hold_data", m_data, prev_data);
        end
        if (dut.state == ERR) checkOutput("no_rd_en_in_err", rd_en, 0);
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_word", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_word = sb.pop_front();
            checkOutput("word_order", m_data, exp_word);
            delivered++;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic              rec_rd[16];
    logic              rec_v[16];
    logic [DATA_W-1:0] rec_d[16];
    int run;
    int pulses;
    int d0;

    // Reset with data waiting in the FIFO.
    applyStimulus(3, 32'h100, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rd_en", rd_en, 0);
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_err_cnt", err_cnt, 0);
    checkOutput("reset_state", dut.state, IDLE);
    checkOutput("reset_m_data", m_data, 0);

    // Streaming eight words with the sink always ready.
    assertReset();
    applyStimulus(8, 32'h11, 32'h11);
    m_ready = 1'b1;
    releaseReset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rec_rd[i] = rd_en;
      rec_v[i]  = m_valid;
      rec_d[i]  = m_data;
    end
    run = 0;
    for (int i = 0; i < 16; i++) begin
      if (rec_rd[i] && run == i) run++;
    end
    checkOutput("stream_rd_en_run", run, 8);
    checkOutput("stream_rd_en_after", rec_rd[8], 0);
    checkOutput("stream_latency", rec_v[1], 0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("stream_valid", rec_v[2 + k], 1);
      checkOutput("stream_data", rec_d[2 + k], 32'h11 * (k + 1));
    end

    // Backpressure: two reads fill the buffer, then drain in order.
    assertReset();
    applyStimulus(5, 32'hA1, 32'h1);
    releaseReset();
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rd_en) pulses++;
    end
    checkOutput("bp_pulses", pulses, 2);
    checkOutput("bp_occ", dut.occ, 2);
    checkOutput("bp_state", dut.state, HOLD);
    checkOutput("bp_valid", m_valid, 1);
    checkOutput("bp_data", m_data, 32'hA1);
    d0 = delivered;
    @(posedge clk); #2;
    m_ready = 1'b1;
    waitDrain(40);
    checkOutput("bp_delivered", delivered - d0, 5);

    // One failed read.
    assertReset();
    applyStimulus(2, 32'h5A, 32'h1);
    force_err = 1;
    m_ready = 1'b1;
    releaseReset();
    @(negedge clk);
    checkOutput("err_first_rd_en", rd_en, 1);
    @(negedge clk);
    checkOutput("err_cnt_before", err_cnt, 0);
    @(negedge clk);
    checkOutput("err_state", dut.state, ERR);
    checkOutput("err_rd_en", rd_en, 0);
    checkOutput("err_cnt_after", err_cnt, 1);
    checkOutput("err_no_valid", m_valid, 0);
    @(negedge clk);
    checkOutput("err_leave_state", dut.state, FETCH);
    checkOutput("err_next_data", m_data, 32'h5A);
    waitDrain(40);
    checkOutput("err_cnt_final", err_cnt, 1);

    // Saturation with a 2-bit counter and five failures.
    assertReset();
    applyStimulus(1, 32'h77, 32'h0);
    force_err = 5;
    m_ready = 1'b1;
    d0 = delivered;
    releaseReset();
    waitDrain(80);
    checkOutput("sat_err_cnt", err_cnt, 3);
    checkOutput("sat_delivered", delivered - d0, 1);

    // Reset in the cycle a read is in flight, then a stray ack with infl=0.
    assertReset();
    applyStimulus(4, 32'hC1, 32'h1);
    m_ready = 1'b1;
    releaseReset();
    @(negedge clk);
    checkOutput("mid_rd_en", rd_en, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    sb.delete();
    fifo_q.delete();
    updateFlags();
    spurious = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_rd_en", rd_en, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_valid", m_valid, 0);
    checkOutput("mid_occ", dut.occ, 0);
    @(negedge clk);
    checkOutput("mid_ack_ignored_valid", m_valid, 0);
    checkOutput("mid_ack_ignored_occ", dut.occ, 0);
    checkOutput("mid_err_cnt", err_cnt, 0);

    // Random traffic, random backpressure, occasional failed reads.
    assertReset();
    releaseReset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      m_ready = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < FIFO_DEPTH && $urandom_range(0, 2) == 0) begin
        fifo_q.push_back($urandom());
      end
      if ($urandom_range(0, 59) == 0) force_err++;
      updateFlags();
    end
    @(posedge clk); #2;
    m_ready = 1'b1;
    waitDrain(200);
    checkOutput("rand_err_cnt", err_cnt, expErr());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
